// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter slice.
//   state_e : arbiter FSM states (IDLE/ADDR/RESP/DONE)
//   owner_e : which requester owns the outstanding transaction
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like memory port shared by fetch and data accesses.
//   master : arbiter side (drives req/wr/wstrb/addr/wdata, takes handshakes + rdata)
//   slave  : memory side
interface mem_bus_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            req;
  logic            wr;
  logic [DW/8-1:0] wstrb;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            addr_ok;
  logic            data_ok;
  logic [DW-1:0]   rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Two-way round-robin selector.
//   req[0]     : instruction fetch request
//   req[1]     : data request
//   last_grant : owner of the previous grant
//   grant      : one-hot grant (bit order matches req); zero when no request
module arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: favour whoever did not win last time.
      2'b11:   grant = (last_grant == OWNER_INST) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and MEM-stage
// data access. One transaction outstanding at a time; round-robin on contention.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   inst_req/addr      : fetch request level + address; inst_ok/inst_rdata on completion
//   data_req/wr/wstrb/addr/wdata : data request; data_ok/data_rdata on completion
//   stall_inst/data    : request pending and not completing this cycle
//   mem                : memory port (master side)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_req,
  input  logic [AW-1:0]      inst_addr,
  output logic [DW-1:0]      inst_rdata,
  output logic               inst_ok,
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [DW/8-1:0]    data_wstrb,
  input  logic [AW-1:0]      data_addr,
  input  logic [DW-1:0]      data_wdata,
  output logic [DW-1:0]      data_rdata,
  output logic               data_ok,
  output logic               stall_inst,
  output logic               stall_data,
  mem_bus_arbiter_if.master  mem
);

  localparam int unsigned SW = DW / 8;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_grant_q, last_grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DW-1:0]   data_rdata_q, data_rdata_d;
  logic [1:0]      grant;

  arb_rr2 u_arb_rr2 (
    .req        ({data_req, inst_req}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant[1]) begin
          owner_d      = OWNER_DATA;
          last_grant_d = OWNER_DATA;
          addr_d       = data_addr;
          wr_d         = data_wr;
          wstrb_d      = data_wstrb;
          wdata_d      = data_wdata;
          state_d      = ADDR;
        end else if (grant[0]) begin
          owner_d      = OWNER_INST;
          last_grant_d = OWNER_INST;
          addr_d       = inst_addr;
          wr_d         = 1'b0;
          wstrb_d      = '0;
          wdata_d      = '0;
          state_d      = ADDR;
        end
      end
      // addr_ok wins over a simultaneous data_ok: data is only taken in RESP.
      ADDR: if (mem.addr_ok) state_d = RESP;
      RESP: begin
        if (mem.data_ok) begin
          if (owner_q == OWNER_DATA) data_rdata_d = mem.rdata;
          else                       inst_rdata_d = mem.rdata;
          state_d = DONE;
        end
      end
      // No grant here: the finishing requester may still hold its req high.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_INST;
      last_grant_q <= OWNER_INST;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign mem.req   = (state_q == ADDR);
  // Write qualifiers are gated so the port never shows a write without a request.
  assign mem.wr    = wr_q & mem.req;
  assign mem.wstrb = mem.req ? wstrb_q : '0;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  assign inst_ok    = (state_q == DONE) && (owner_q == OWNER_INST);
  assign data_ok    = (state_q == DONE) && (owner_q == OWNER_DATA);
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assign stall_inst = inst_req & ~inst_ok;
  assign stall_data = data_req & ~data_ok;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, data_req, data_wr;
  logic [31:0]   inst_addr, data_addr, data_wdata;
  logic [3:0]    data_wstrb;
  logic [31:0]   inst_rdata, data_rdata;
  logic          inst_ok, data_ok, stall_inst, stall_data;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) mif ();

  mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ok    (inst_ok),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_wstrb (data_wstrb),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_ok    (data_ok),
    .stall_inst (stall_inst),
    .stall_data (stall_data),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a granted transaction waits for acceptance,
  // then for its response, then announces completion for one cycle.
  bit          m_busy, m_acc, m_pulse, m_owner, m_last; // owner/last: 1 = data
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic        m_wr;
  logic [3:0]  m_wstrb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_acc = 0; m_pulse = 0; m_owner = 0; m_last = 0;
      m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0; m_wr = 0; m_wstrb = 0;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (!m_busy) begin
      if (inst_req || data_req) begin
        m_owner = (inst_req && data_req) ? !m_last : data_req;
        m_last  = m_owner;
        m_busy  = 1;
        m_acc   = 0;
        m_addr  = m_owner ? data_addr : inst_addr;
        m_wr    = m_owner ? data_wr : 1'b0;
        m_wstrb = m_owner ? data_wstrb : 4'b0;
        m_wdata = m_owner ? data_wdata : 32'b0;
      end
    end else if (!m_acc) begin
      if (mif.addr_ok) m_acc = 1;
    end else if (mif.data_ok) begin
      if (m_owner) m_drdata = mif.rdata;
      else         m_irdata = mif.rdata;
      m_busy  = 0;
      m_acc   = 0;
      m_pulse = 1;
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    logic e_req;
    e_req = m_busy && !m_acc;
    chk("mem_req", mif.req, e_req);
    chk("inst_ok", inst_ok, m_pulse && !m_owner);
    chk("data_ok", data_ok, m_pulse && m_owner);
    chk("inst_rdata", inst_rdata, m_irdata);
    chk("data_rdata", data_rdata, m_drdata);
    chk("stall_inst", stall_inst, inst_req && !(m_pulse && !m_owner));
    chk("stall_data", stall_data, data_req && !(m_pulse && m_owner));
    if (e_req) begin
      chk("mem_addr", mif.addr, m_addr);
      chk("mem_wr", mif.wr, m_wr);
      chk("mem_wstrb", mif.wstrb, m_wstrb);
      if (m_wr) chk("mem_wdata", mif.wdata, m_wdata);
    end
    if (!rst) begin
      chk("rst_mem_addr", mif.addr, 0);
      chk("rst_mem_wdata", mif.wdata, 0);
      chk("rst_mem_wr", mif.wr, 0);
      chk("rst_mem_wstrb", mif.wstrb, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Well-behaved memory: accept immediately, respond on the next cycle.
  task automatic mem_cycle();
    step();
    mif.addr_ok = mif.req;
    mif.data_ok = !mif.req;
    mif.rdata   = $urandom;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((inst_req || data_req) && n < budget) begin
      mem_cycle();
      if (inst_ok) inst_req = 0;
      if (data_ok) data_req = 0;
      n++;
    end
    chk("drain_done", {30'b0, inst_req, data_req}, 0);
    mif.addr_ok = 0;
    mif.data_ok = 0;
  endtask

  initial begin
    int     cnt, oks_i, oks_d, ngr;
    bit     prev_req, i_seen, d_seen;
    logic   order [4];
    rst = 0; inst_req = 0; data_req = 0; data_wr = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
    mif.addr_ok = 0; mif.data_ok = 0; mif.rdata = 0;

    // Reset held with both requests pending.
    inst_req = 1; data_req = 1;
    inst_addr = 32'hBFC0_0000; data_addr = 32'h8000_0020;
    repeat (3) step();
    @(negedge clk);
    chk("rst_req", mif.req, 0);
    chk("rst_inst_ok", inst_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    step();
    rst = 1;
    step();
    @(negedge clk);
    chk("first_grant_req", mif.req, 1);
    chk("first_grant_addr", mif.addr, 32'h8000_0020);
    drain(40);

    // Single fetch at minimum latency, then a back-to-back held request.
    step();
    inst_req = 1; inst_addr = 32'hBFC0_0000; mif.addr_ok = 1; mif.data_ok = 0;
    @(negedge clk);
    chk("fetch_c0_stall", stall_inst, 1);
    chk("fetch_c0_req", mif.req, 0);
    step();
    @(negedge clk);
    chk("fetch_c1_req", mif.req, 1);
    chk("fetch_c1_addr", mif.addr, 32'hBFC0_0000);
    chk("fetch_c1_stall", stall_inst, 1);
    step();
    mif.addr_ok = 0; mif.data_ok = 1; mif.rdata = 32'h2408_0001;
    @(negedge clk);
    chk("fetch_c2_req", mif.req, 0);
    chk("fetch_c2_stall", stall_inst, 1);
    chk("fetch_c2_ok", inst_ok, 0);
    step();
    mif.data_ok = 0;
    @(negedge clk);
    chk("fetch_c3_ok", inst_ok, 1);
    chk("fetch_c3_rdata", inst_rdata, 32'h2408_0001);
    chk("fetch_c3_stall", stall_inst, 0);
    step();
    inst_addr = 32'hBFC0_0004; mif.addr_ok = 1;
    @(negedge clk);
    chk("b2b_no_regrant", mif.req, 0);
    chk("b2b_no_ok", inst_ok, 0);
    step();
    @(negedge clk);
    chk("b2b_next_grant", mif.req, 1);
    chk("b2b_next_addr", mif.addr, 32'hBFC0_0004);
    drain(40);

    // Contention: both requests held continuously.
    step();
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2000; data_wr = 0; data_wstrb = 0;
    oks_i = 0; oks_d = 0; ngr = 0; prev_req = 0; cnt = 0;
    while (oks_i + oks_d < 4 && cnt < 60) begin
      mem_cycle();
      @(negedge clk);
      if (mif.req && !prev_req && ngr < 4) begin
        order[ngr] = (mif.addr == 32'h0000_2000);
        ngr++;
      end
      prev_req = mif.req;
      oks_i += int'(inst_ok);
      oks_d += int'(data_ok);
      cnt++;
    end
    chk("cont_grants", ngr, 4);
    chk("cont_order0", order[0], 1);
    chk("cont_order1", order[1], 0);
    chk("cont_order2", order[2], 1);
    chk("cont_order3", order[3], 0);
    chk("cont_inst_oks", oks_i, 2);
    chk("cont_data_oks", oks_d, 2);
    step();
    inst_req = 0; data_req = 0;
    mif.addr_ok = 0; mif.data_ok = 0;
    step();

    // Store with delayed address acceptance.
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011;
    data_addr = 32'h8000_0010; data_wdata = 32'h0000_BEEF;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("store_req", mif.req, 1);
      chk("store_wr", mif.wr, 1);
      chk("store_wstrb", mif.wstrb, 4'b0011);
      chk("store_wdata", mif.wdata, 32'h0000_BEEF);
      step();
    end
    mif.addr_ok = 1;
    @(negedge clk);
    chk("store_wait_req", mif.req, 1);
    step();
    mif.addr_ok = 0; mif.data_ok = 1; mif.rdata = 32'h1234_5678;
    step();
    mif.data_ok = 0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cnt += int'(data_ok);
      step();
      data_req = 0; data_wr = 0; data_wstrb = 0;
    end
    chk("store_ok_pulses", cnt, 1);

    // Reset during RESP, stale response afterwards.
    inst_req = 1; inst_addr = 32'h0000_0040; mif.addr_ok = 1;
    step();
    step();
    mif.addr_ok = 0;
    @(negedge clk);
    chk("midop_resp_req", mif.req, 0);
    step();
    rst = 0; inst_req = 0;
    @(negedge clk);
    chk("midop_rst_ok", inst_ok, 0);
    step();
    rst = 1; mif.data_ok = 1; mif.rdata = 32'hDEAD_BEEF;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cnt += int'(inst_ok) + int'(data_ok);
      step();
    end
    chk("midop_no_ok", cnt, 0);
    mif.data_ok = 0;
    data_req = 1; data_addr = 32'h0000_0044;
    step();
    @(negedge clk);
    chk("midop_idle_grant", mif.req, 1);
    chk("midop_idle_addr", mif.addr, 32'h0000_0044);
    drain(40);

    // Randomized traffic with a misbehaving-timing memory and rare resets.
    i_seen = 0; d_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!rst) rst = 1;
      else if ($urandom_range(0, 599) == 0) rst = 0;
      mif.addr_ok = ($urandom_range(0, 2) != 0);
      mif.data_ok = ($urandom_range(0, 2) != 0);
      mif.rdata   = $urandom;
      if (i_seen) begin
        i_seen = 0;
        inst_req = $urandom_range(0, 1) != 0;
        inst_addr = $urandom;
      end else if (!inst_req) begin
        if ($urandom_range(0, 2) == 0) begin inst_req = 1; inst_addr = $urandom; end
      end else if (inst_ok) begin
        i_seen = 1;
      end else if (!(!m_owner && (m_busy || m_pulse)) && $urandom_range(0, 15) == 0) begin
        inst_req = 0;
      end
      if (d_seen) begin
        d_seen = 0;
        data_req = $urandom_range(0, 1) != 0;
        data_addr = $urandom; data_wdata = $urandom;
        data_wr = $urandom_range(0, 1) != 0; data_wstrb = 4'($urandom);
      end else if (!data_req) begin
        if ($urandom_range(0, 2) == 0) begin
          data_req = 1; data_addr = $urandom; data_wdata = $urandom;
          data_wr = $urandom_range(0, 1) != 0; data_wstrb = 4'($urandom);
        end
      end else if (data_ok) begin
        d_seen = 1;
      end else if (!(m_owner && (m_busy || m_pulse)) && $urandom_range(0, 15) == 0) begin
        data_req = 0;
      end
    end
    rst = 1;
    drain(60);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory port between instruction fetch (pcF/instrF) and the MEM-stage data access (aluoutM, writedataM, sig_write, memwriteM).
- Only one transaction is outstanding at a time.
- When both requesters are pending, priority alternates between them.
- Outputs per-requester stall levels for the hazard unit. Sits between datapath and the top-level memory interface.

Parameters:
- AW, 32, address width.
- DW, 32, data width; write-strobe width is DW/8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst_req  input  1  fetch request level; held until inst_ok.
- inst_addr  input  AW  fetch address (pcF).
- inst_rdata  output  DW  fetched word; valid while inst_ok=1.
- inst_ok  output  1  one-cycle completion pulse for fetch.
- data_req  input  1  data request level; held until data_ok.
- data_wr  input  1  1=store, 0=load (memwriteM).
- data_wstrb  input  DW/8  byte enables (sig_write).
- data_addr  input  AW  data address (aluoutM).
- data_wdata  input  DW  store data (writedataM).
- data_rdata  output  DW  load word; valid while data_ok=1.
- data_ok  output  1  one-cycle completion pulse for data.
- stall_inst  output  1  inst_req=1 and inst_ok=0.
- stall_data  output  1  data_req=1 and data_ok=0.
- mem_req  output  1  memory request valid.
- mem_wr  output  1  write enable to memory.
- mem_wstrb  output  DW/8  byte enables to memory; 0 for reads.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_addr_ok  input  1  memory accepted the request this cycle.
- mem_data_ok  input  1  memory completed the transaction this cycle.
- mem_rdata  input  DW  read data, valid with mem_data_ok.

Behaviour:
- States:
  - IDLE: arbitrate.
  - ADDR: mem_req=1, hold the latched request.
  - RESP: wait for mem_data_ok.
  - DONE: pulse ok for exactly one cycle.
- Reset values: state=IDLE, owner=INST, last_grant=INST, mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, inst_ok=0, data_ok=0, inst_rdata=0, data_rdata=0.
- IDLE grant rules:
  - If only one request is present, grant it.
  - If both are present, grant the requester opposite last_grant; after reset, data wins first.
  - On grant: latch the granted request's addr, wr, wstrb, wdata into registers; set owner and last_grant; go to ADDR.
  - Instruction requests are always latched with wr=0 and wstrb=0.
- ADDR: mem_* outputs are driven from the latched registers. On mem_addr_ok go to RESP and drop mem_req in that same transition. mem_req stays 1 until addr_ok; the latched request is never altered while waiting.
- RESP: on mem_data_ok, latch mem_rdata into the owner's rdata register and go to DONE.
- DONE: assert the owner's ok for one cycle, then go to IDLE. The other requester's ok stays 0.
  - No grant is made in DONE. This prevents re-accepting a request the requester has not yet dropped.
- Minimum latency: request seen at cycle 0 → ok at cycle 3, when addr_ok and data_ok each arrive on their first possible cycle.
- Simultaneous mem_addr_ok and mem_data_ok in ADDR: treat as addr_ok only. The memory must not return data in the same cycle it accepts the address.
- mem_data_ok outside RESP is ignored; this covers a stale response after reset.
- Request withdrawn before grant: nothing happens. Withdrawal after grant is illegal; the latched transaction completes regardless.
- Async reset asserted mid-transaction: return to IDLE immediately and clear all outputs; no ok pulse is produced.
- Stall outputs are combinational from req and ok.
- Round-robin bound: neither requester waits more than one competing transaction.

Decomposition:
- Shared defines header (codebase `define file): state encodings (IDLE=2'd0, ADDR=2'd1, RESP=2'd2, DONE=2'd3) and OWNER_INST=1'b0, OWNER_DATA=1'b1.
- One natural sub-module, arb_rr2: a 2-way round-robin selector.
  - Inputs: req[1:0], last_grant.
  - Output: one-hot grant.
  - Used only in IDLE.
- FSM and latch registers stay in mem_bus_arbiter.

Test Plan:
- Reset: hold rst=0 with both reqs=1 → all mem_* and ok outputs 0; release → data granted first, mem_addr=data_addr.
- Single fetch: inst_addr=0xBFC00000, addr_ok immediate, data_ok next cycle with rdata=0x24080001 → inst_ok high at cycle 3 with inst_rdata=0x24080001; stall_inst high cycles 0–2.
- Store: data_wr=1, wstrb=4'b0011, addr=0x80000010, wdata=0x0000BEEF → mem_wr=1 and mem_wstrb=0011 held through 3 cycles of addr_ok=0; data_ok pulses once.
- Contention: both reqs held continuously → grant order DATA, INST, DATA, INST; each requester gets exactly one ok per two transactions.
- Reset mid-op: assert rst=0 during RESP, then feed mem_data_ok in IDLE → no ok pulse; state IDLE.
- Back-to-back: inst_req held high across an ok → the same request is not re-accepted in DONE; the next grant occurs the cycle after DONE.
